// File: rtl/temp_link_pkg.sv
// Shared definitions for both ends of the temperature serial link.
// Covers the frame geometry, the state encoding and the idle line level.
package temp_link_pkg;
   localparam int   FRAME_BITS     = 12;
   localparam int   MIN_GUARD_BITS = 2;
   localparam int   MAX_GUARD_BITS = 15;
   localparam int   MAX_BIT_CYCLES = 255;
   localparam logic IDLE_LEVEL     = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_GUARD = 2'd3
   } link_state_e;

   typedef logic [FRAME_BITS-1:0] temp_word_t;
endpackage

// File: rtl/bit_timer.sv
// Bit-period timer for the link. It strobes bit_end_o on the last clock of each bit period.
// It also flags bit_end_nxt_o one clock earlier, so registered outputs can line up with the strobe.
module bit_timer
   import temp_link_pkg::*;
#(
   parameter int BIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic bit_end_o,
   output logic bit_end_nxt_o
);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   if (BIT_CYCLES < 1 || BIT_CYCLES > MAX_BIT_CYCLES) begin : g_bad_bit_cycles
      $error("bit_timer: BIT_CYCLES must be within 1..255");
   end

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end_o = (cnt_q == CW'(BIT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || bit_end_o) cnt_d = '0;
   end

   if (BIT_CYCLES == 1) begin : g_nxt_single
      assign bit_end_nxt_o = 1'b1;
   end else begin : g_nxt_multi
      // After a clear the count restarts at 0, which is never the last clock here.
      assign bit_end_nxt_o = !clear_i && (cnt_q == CW'(BIT_CYCLES - 2));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/temp_serial_tx.sv
// Serial transmitter for 12-bit temperature words.
// The frame is one start bit, 12 data bits MSB first, then GUARD_BITS high bit times.
module temp_serial_tx
   import temp_link_pkg::*;
#(
   parameter int BIT_CYCLES = 1,
   parameter int GUARD_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FRAME_BITS-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  serial_data,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int GW = $clog2(GUARD_BITS);

   if (BIT_CYCLES < 1 || BIT_CYCLES > MAX_BIT_CYCLES) begin : g_bad_bit_cycles
      $error("temp_serial_tx: BIT_CYCLES must be within 1..255");
   end
   if (GUARD_BITS < MIN_GUARD_BITS || GUARD_BITS > MAX_GUARD_BITS) begin : g_bad_guard_bits
      $error("temp_serial_tx: GUARD_BITS must be within 2..15");
   end

   link_state_e     state_q;
   temp_word_t      shreg_q;
   logic [3:0]      bitcnt_q;
   logic [GW-1:0]   gc_q;
   logic            serial_q, ready_q, busy_q, done_q;

   logic            accept, bit_end, bit_end_nxt, last_guard;
   logic [GW-1:0]   gc_d;

   assign accept     = tx_valid && ready_q;
   assign last_guard = (gc_q == GW'(GUARD_BITS - 1));
   assign gc_d       = gc_q + GW'(bit_end);

   bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (accept),
      .bit_end_o    (bit_end),
      .bit_end_nxt_o(bit_end_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gc_q     <= '0;
         serial_q <= IDLE_LEVEL;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               ready_q  <= 1'b1;
               serial_q <= IDLE_LEVEL;
               if (accept) begin
                  state_q  <= ST_START;
                  shreg_q  <= tx_data;
                  bitcnt_q <= '0;
                  gc_q     <= '0;
                  serial_q <= ~IDLE_LEVEL;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state_q  <= ST_DATA;
                  serial_q <= shreg_q[FRAME_BITS-1];
                  shreg_q  <= {shreg_q[FRAME_BITS-2:0], 1'b0};
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bitcnt_q == 4'(FRAME_BITS - 1)) begin
                     state_q  <= ST_GUARD;
                     serial_q <= IDLE_LEVEL;
                     gc_q     <= '0;
                  end else begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                     serial_q <= shreg_q[FRAME_BITS-1];
                     shreg_q  <= {shreg_q[FRAME_BITS-2:0], 1'b0};
                  end
               end
            end
            ST_GUARD: begin
               if (bit_end && last_guard) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  gc_q   <= gc_d;
                  // Raise frame_done so that it lands exactly on the final guard clock.
                  done_q <= (gc_d == GW'(GUARD_BITS - 1)) && bit_end_nxt;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_ready    = ready_q;
   assign serial_data = serial_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
endmodule

// File: tb/tb_temp_serial_tx.sv
// Directed and randomized checks of temp_serial_tx against a frame-level line model
// and a looped-back receiver. Covers defaults and a slow configuration (BIT_CYCLES=4, GUARD_BITS=3).
module tb_temp_serial_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] tx_data [2];
   logic        tx_valid [2];
   logic        tx_ready [2];
   logic        serial_data [2];
   logic        busy [2];
   logic        frame_done [2];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int done_cnt0   = 0;
   int done_cnt1   = 0;
   int last_start [2];

   always #5 clk = ~clk;

   temp_serial_tx #(.BIT_CYCLES(1), .GUARD_BITS(2)) u_dut_def (
      .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .serial_data(serial_data[0]), .busy(busy[0]),
      .frame_done(frame_done[0])
   );

   temp_serial_tx #(.BIT_CYCLES(4), .GUARD_BITS(3)) u_dut_slow (
      .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .serial_data(serial_data[1]), .busy(busy[1]),
      .frame_done(frame_done[1])
   );

   always @(negedge clk) begin
      if (frame_done[0] === 1'b1) done_cnt0++;
      if (frame_done[1] === 1'b1) done_cnt1++;
   end

   function automatic int bc(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic int gb(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic int dcnt(input int k);
      return (k == 0) ? done_cnt0 : done_cnt1;
   endfunction

   // Expected line level n clocks after the first start clock.
   function automatic logic exp_line(input logic [11:0] w, input int n, input int b);
      int slot;
      slot = n / b;
      if (slot == 0) return 1'b0;
      if (slot <= 12) return w[12-slot];
      return 1'b1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input int k, input string tag);
      chk($sformatf("%s_ready%0d", tag, k), 32'(tx_ready[k]), 32'd1);
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 32'd0);
      chk($sformatf("%s_line%0d", tag, k), 32'(serial_data[k]), 32'd1);
      chk($sformatf("%s_done%0d", tag, k), 32'(frame_done[k]), 32'd0);
   endtask

   // Entered in an IDLE cycle; leaves in the IDLE cycle after the frame.
   task automatic send_frame(input int k, input logic [11:0] w, input bit hold,
                             input logic [11:0] other, input bit chained);
      int          b, g, len, d0;
      logic        smp[$];
      logic [11:0] rx;
      b   = bc(k);
      g   = gb(k);
      len = (13 + g) * b;
      chk($sformatf("pre_ready%0d", k), 32'(tx_ready[k]), 32'd1);
      tx_data[k]  = w;
      tx_valid[k] = 1'b1;
      d0 = dcnt(k);
      tick;
      if (chained) chk($sformatf("start_spacing%0d", k), 32'(cyc - last_start[k]), 32'(len + 1));
      last_start[k] = cyc;
      tx_valid[k] = hold;
      tx_data[k]  = other;
      for (int n = 0; n < len; n++) begin
         chk($sformatf("line%0d_n%0d", k, n), 32'(serial_data[k]), 32'(exp_line(w, n, b)));
         chk($sformatf("done%0d_n%0d", k, n), 32'(frame_done[k]), 32'(n == len - 1));
         chk($sformatf("ready%0d_n%0d", k, n), 32'(tx_ready[k]), 32'd0);
         chk($sformatf("busy%0d_n%0d", k, n), 32'(busy[k]), 32'd1);
         smp.push_back(serial_data[k]);
         tick;
      end
      chk($sformatf("rx_start%0d", k), 32'(smp[b/2]), 32'd0);
      for (int i = 0; i < 12; i++) rx[11-i] = smp[(i + 1) * b + b / 2];
      chk($sformatf("rx_word%0d", k), 32'(rx), 32'(w));
      chk($sformatf("done_once%0d", k), 32'(dcnt(k) - d0), 32'd1);
      chk_idle(k, "post");
   endtask

   initial begin
      logic [11:0] w;
      bit          h, prev_h;
      int          d0;
      last_start[0] = 0;
      last_start[1] = 0;
      for (int k = 0; k < 2; k++) begin
         tx_data[k]  = '0;
         tx_valid[k] = 1'b0;
      end

      // Reset state, then ready on the first edge after release.
      repeat (3) tick;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_line%0d", k), 32'(serial_data[k]), 32'd1);
         chk($sformatf("rst_ready%0d", k), 32'(tx_ready[k]), 32'd0);
         chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
         chk($sformatf("rst_done%0d", k), 32'(frame_done[k]), 32'd0);
      end
      rst = 1'b1;
      #1;
      chk("rel_ready0", 32'(tx_ready[0]), 32'd0);
      tick;
      chk_idle(0, "rel");
      chk_idle(1, "rel");

      // 0x5A3 at defaults.
      send_frame(0, 12'h5A3, 1'b0, 12'hFFF, 1'b0);
      // Back-to-back with valid held: 0xFFF then 0x000.
      send_frame(0, 12'hFFF, 1'b1, 12'h000, 1'b0);
      send_frame(0, 12'h000, 1'b0, 12'h555, 1'b1);
      // Intruding word during a frame is held off until IDLE.
      send_frame(0, 12'hABC, 1'b1, 12'h123, 1'b0);
      send_frame(0, 12'h123, 1'b0, 12'hEEE, 1'b1);
      // Slow configuration: 4 clocks per bit, 64-clock frame.
      send_frame(1, 12'h801, 1'b0, 12'h7FE, 1'b0);

      // Mid-frame reset at data bit 5 of 0x3C7.
      d0 = done_cnt0;
      tx_data[0]  = 12'h3C7;
      tx_valid[0] = 1'b1;
      tick;
      tx_valid[0] = 1'b0;
      repeat (7) tick;
      chk("abort_pre_line", 32'(serial_data[0]), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("abort_line", 32'(serial_data[0]), 32'd1);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_ready", 32'(tx_ready[0]), 32'd0);
      tick;
      tick;
      rst = 1'b1;
      tick;
      chk_idle(0, "abort_rel");
      chk("abort_no_done", 32'(done_cnt0 - d0), 32'd0);
      send_frame(0, 12'h001, 1'b0, 12'h3C7, 1'b0);

      // Randomized words, holds and idle gaps on both configurations.
      for (int k = 0; k < 2; k++) begin
         tick;
         prev_h = 1'b0;
         for (int r = 0; r < ((k == 0) ? 10 : 4); r++) begin
            w = 12'($urandom_range(0, 4095));
            h = 1'($urandom_range(0, 1));
            if (!prev_h) begin
               repeat ($urandom_range(0, 3)) begin
                  tick;
                  chk_idle(k, "gap");
               end
            end
            send_frame(k, w, h, 12'($urandom_range(0, 4095)), prev_h);
            prev_h = h;
         end
         tx_valid[k] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/temp_serial_tx.md
TEMP_SERIAL_TX -- requirements
Module: temp_serial_tx

Interface
REQ-001 Parameter BIT_CYCLES, default 1, clocks per serial bit; legal range 1..255.
REQ-002 Parameter GUARD_BITS, default 2, high-level bit times after the last data bit; legal range 2..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-005 tx_data  input  12  temperature word to send; sampled only at acceptance.
REQ-006 tx_valid  input  1  requester has a word on tx_data.
REQ-007 tx_ready  output  1  block can accept a word this cycle.
REQ-008 serial_data  output  1  registered serial line; idle level 1.
REQ-009 busy  output  1  frame in progress (any state other than IDLE).
REQ-010 frame_done  output  1  one-clock pulse on the final guard clock of each frame.

Function
REQ-011 States SHALL be IDLE, START, DATA and GUARD, with one-hot or binary encoding allowed.
REQ-012 In IDLE: tx_ready=1, busy=0 and serial_data=1.
REQ-013 Acceptance SHALL occur on the rising edge where tx_valid=1 and tx_ready=1: latch tx_data into a 12-bit shift register, clear the bit-timer and the bit counter, and go to START.
REQ-014 tx_ready SHALL be 0 in START, DATA and GUARD; tx_valid and tx_data in those states SHALL be ignored with no effect.
REQ-015 START: serial_data=0 for exactly BIT_CYCLES clocks, beginning the clock after acceptance; then go to DATA.
REQ-016 DATA: send 12 bits MSB first, bit 11 first and bit 0 last, each held for BIT_CYCLES clocks; then go to GUARD.
REQ-017 GUARD: serial_data=1 for GUARD_BITS*BIT_CYCLES clocks; frame_done=1 on the final clock; then go to IDLE.
REQ-018 Frame length from the first start clock to the last guard clock SHALL be (13+GUARD_BITS)*BIT_CYCLES clocks.
REQ-019 With tx_valid held at 1, start bits SHALL be spaced (13+GUARD_BITS)*BIT_CYCLES+1 clocks apart, which is 16 clocks at the defaults.
REQ-020 The bit-timer SHALL count 0..BIT_CYCLES-1 and wrap. The bit counter SHALL be 4 bits and count 0..11 in DATA with no overflow. The guard counter SHALL be wide enough for GUARD_BITS.
REQ-021 serial_data SHALL be driven directly from a flop and SHALL be glitch-free.
REQ-022 At the defaults, the frame SHALL be decoded bit-exactly by the team's display-side receiver: a low start sample, 12 MSB-first samples, and at least 2 high clocks before the next start.
REQ-023 If tx_valid drops after acceptance, the frame SHALL still complete unchanged.

Reset
REQ-024 While rst=0: state=IDLE, serial_data=1, tx_ready=0, busy=0, frame_done=0, all counters and the shift register 0.
REQ-025 On the first rising clk edge after rst returns to 1, tx_ready SHALL be 1.
REQ-026 A reset asserted mid-frame SHALL abort the frame immediately: the line returns high asynchronously, no frame_done is issued, and the latched word is discarded.

Structure
REQ-027 Shared package temp_link_pkg SHALL hold FRAME_BITS=12, MIN_GUARD_BITS=2, the state typedef and the idle line level, for use by both link ends.
REQ-028 One sub-module, bit_timer, SHALL generate a one-clock bit_end strobe every BIT_CYCLES clocks. It SHALL have clk and rst ports and a clear input driven on acceptance.
REQ-029 The parameter ranges SHALL be elaboration-time checked.

Verification
REQ-030 Defaults, send 0x5A3 -> serial_data over 15 clocks reads 0,0,1,0,1,1,0,1,0,0,0,1,1,1,1; frame_done pulses on clock 15; a looped-back receiver reports 0x5A3.
REQ-031 tx_valid held high with 0xFFF then 0x000 -> start bits 16 clocks apart; a low start bit appears only after two high guard clocks; the receiver reports 0xFFF then 0x000.
REQ-032 BIT_CYCLES=4, GUARD_BITS=3, send 0x801 -> each bit lasts 4 clocks; the frame is 64 clocks; frame_done occurs exactly once.
REQ-033 During DATA, tx_valid=1 with tx_data=0x123 -> tx_ready stays 0; the in-flight 0xABC frame is unchanged; 0x123 is sent only after IDLE.
REQ-034 rst pulsed low at data bit 5 of 0x3C7 -> serial_data is 1 within the same cycle; no frame_done; tx_ready=1 one clock after release; the next word 0x001 is sent correctly.
